// File: rtl/board_grant_dispatch.sv
// Grant-side consumer for the 8-way round-robin board arbiter.
// Requests a grant, then streams the granted board's head packet out.
module board_grant_dispatch #(
  parameter int NUM_BOARDS = 8,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 8,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_BOARDS-1:0]           board_req,
  input  logic [NUM_BOARDS*DATA_WIDTH-1:0] board_data,
  input  logic [NUM_BOARDS*LEN_WIDTH-1:0] board_len,
  output logic [NUM_BOARDS-1:0]           board_pop,
  output logic [NUM_BOARDS-1:0]           arb_mask,
  output logic                            arb_enable,
  input  logic [NUM_BOARDS-1:0]           arb_grant,
  input  logic [SEL_WIDTH-1:0]            arb_board_sel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic [SEL_WIDTH-1:0]            out_board,
  output logic                            busy
);

  localparam logic [SEL_WIDTH-1:0] NO_SEL = SEL_WIDTH'(NUM_BOARDS);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    XFER
  } state_t;

  state_t                state, state_nxt;
  logic [SEL_WIDTH-1:0]  cur_sel, cur_sel_nxt;
  logic [LEN_WIDTH-1:0]  len_q, len_nxt;
  logic [LEN_WIDTH-1:0]  cnt, cnt_nxt;

  logic [NUM_BOARDS-1:0] sel_dec;
  logic [NUM_BOARDS-1:0] cur_dec;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  any_req;
  logic                  other_req;
  logic                  sel_ok;
  logic                  cur_req;
  logic                  last_word;

  assign arb_mask  = board_req;
  assign any_req   = |board_req;
  assign out_board = cur_sel;
  assign busy      = (state != IDLE);

  assign sel_dec = (arb_board_sel < NO_SEL) ?
                   (NUM_BOARDS'(1) << arb_board_sel) : '0;
  assign cur_dec = (cur_sel < NO_SEL) ?
                   (NUM_BOARDS'(1) << cur_sel) : '0;

  // A grant is usable only if mask and select agree and the board still asks
  assign sel_ok = (sel_dec != '0)
               && (arb_grant == sel_dec)
               && |(board_req & sel_dec);

  assign cur_req   = |(board_req & cur_dec);
  assign other_req = |(board_req & ~cur_dec);
  assign last_word = (cnt == (len_q - LEN_WIDTH'(1)));

  always_comb begin
    sel_len  = '0;
    cur_data = '0;
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (sel_dec[i])
        sel_len = board_len[i*LEN_WIDTH +: LEN_WIDTH];
      if (cur_dec[i])
        cur_data = board_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_nxt   = state;
    cur_sel_nxt = cur_sel;
    len_nxt     = len_q;
    cnt_nxt     = cnt;
    arb_enable  = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    out_last    = 1'b0;
    board_pop   = '0;
    unique case (state)
      IDLE: begin
        if (any_req)
          state_nxt = REQ;
      end
      REQ: begin
        arb_enable = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (sel_ok) begin
          cur_sel_nxt = arb_board_sel;
          len_nxt     = (sel_len == '0) ? LEN_WIDTH'(1) : sel_len;
          cnt_nxt     = '0;
          state_nxt   = XFER;
        end else begin
          state_nxt = any_req ? REQ : IDLE;
        end
      end
      XFER: begin
        out_valid = cur_req;
        out_data  = cur_data;
        out_last  = last_word;
        if (cur_req && out_ready) begin
          board_pop = cur_dec;
          cnt_nxt   = cnt + LEN_WIDTH'(1);
          // The board being popped still shows its request this cycle
          if (last_word)
            state_nxt = other_req ? REQ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur_sel <= NO_SEL;
      len_q   <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      cur_sel <= cur_sel_nxt;
      len_q   <= len_nxt;
      cnt     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_board_grant_dispatch.sv
// Directed bench for board_grant_dispatch.
// Models per-board FIFOs and a round-robin arbiter excluding the last winner.
module tb_board_grant_dispatch;

  localparam int NB = 8;
  localparam int DW = 256;
  localparam int LW = 8;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NB-1:0]   board_req;
  logic [NB*DW-1:0] board_data;
  logic [NB*LW-1:0] board_len;
  logic [NB-1:0]   board_pop;
  logic [NB-1:0]   arb_mask;
  logic            arb_enable;
  logic [NB-1:0]   arb_grant;
  logic [SW-1:0]   arb_board_sel;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [SW-1:0]   out_board;
  logic            busy;

  int            load [NB] = '{default: 0};
  int            hlen [NB] = '{default: 0};
  logic [NB-1:0] hold = '0;
  logic [15:0]   popcnt [NB] = '{default: 16'd0};

  logic [31:0] wd [64];
  int          n_w  = 0;
  int          n_en = 0;
  int          viol = 0;

  int n_tests = 0;
  int n_fail  = 0;

  int   arb_last = 7;
  bit   arb_excl = 1'b0;
  int   pick;

  board_grant_dispatch dut (
    .clk           (clk),
    .rst           (rst),
    .board_req     (board_req),
    .board_data    (board_data),
    .board_len     (board_len),
    .board_pop     (board_pop),
    .arb_mask      (arb_mask),
    .arb_enable    (arb_enable),
    .arb_grant     (arb_grant),
    .arb_board_sel (arb_board_sel),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_board     (out_board),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // FIFO heads: data word carries {board, word index}
  always_comb begin
    board_req  = '0;
    board_len  = '0;
    board_data = '0;
    for (int i = 0; i < NB; i++) begin
      board_req[i] = (load[i] > int'(popcnt[i])) && !hold[i];
      board_len[i*LW +: LW] = LW'(hlen[i]);
      board_data[i*DW +: DW] = {224'd0, 16'(i), popcnt[i]};
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (board_pop[i])
        popcnt[i] <= popcnt[i] + 16'd1;
  end

  function automatic int rr_pick(input logic [NB-1:0] m,
                                 input int last, input bit excl);
    for (int k = 1; k <= NB; k++) begin
      if (k == NB && excl)
        return NB;
      if (m[(last + k) % NB])
        return (last + k) % NB;
    end
    return NB;
  endfunction

  always_comb pick = rr_pick(arb_mask, arb_last, arb_excl);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_grant     <= '0;
      arb_board_sel <= SW'(NB);
      arb_last      <= 7;
      arb_excl      <= 1'b0;
    end else if (arb_enable) begin
      if (pick == NB) begin
        arb_grant     <= '0;
        arb_board_sel <= SW'(NB);
        arb_excl      <= 1'b0;
      end else begin
        arb_grant     <= NB'(1) << pick;
        arb_board_sel <= SW'(pick);
        arb_last      <= pick;
        arb_excl      <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (arb_enable)
        n_en <= n_en + 1;
      if (out_valid && out_ready) begin
        wd[n_w[5:0]] <= {4'd0, out_board, out_data[15:0], 7'd0, out_last};
        n_w <= n_w + 1;
      end
      if ($countones(board_pop) > 1
          || (board_pop != '0 && !(out_valid && out_ready))
          || (out_valid && out_data[31:16] != {12'd0, out_board})
          || (arb_enable && (out_valid || board_pop != '0)))
        viol <= viol + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int b, input int i, input bit l);
    return {8'(b), 16'(i), 7'd0, l};
  endfunction

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_en(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (arb_enable) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy && board_req == '0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_board"}, 64'(out_board), 64'd8);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_en"},    64'(arb_enable), 64'd0);
    check({tag, "_pop"},   64'(board_pop), 64'd0);
    check({tag, "_data"},  64'(out_data), 64'd0);
    check({tag, "_last"},  64'(out_last), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int w0;
    int acc;
    int pat [9];
    rst       = 1'b1;
    out_ready = 1'b0;
    #2;
    check_reset("rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: boards 0 and 2
    out_ready = 1'b1;
    hlen[0] = 3;
    hlen[2] = 1;
    load[0] = 3;
    load[2] = 1;
    e0 = n_en;
    w0 = n_w;
    wait_done("t1_done");
    check("t1_en", 64'(n_en - e0), 64'd2);
    check("t1_nw", 64'(n_w - w0), 64'd4);
    check("t1_w0", 64'(wd[w0]),   64'(enc(0, 0, 0)));
    check("t1_w1", 64'(wd[w0+1]), 64'(enc(0, 1, 0)));
    check("t1_w2", 64'(wd[w0+2]), 64'(enc(0, 2, 1)));
    check("t1_w3", 64'(wd[w0+3]), 64'(enc(2, 0, 1)));
    check("t1_pop0", 64'(popcnt[0]), 64'd3);
    check("t1_pop2", 64'(popcnt[2]), 64'd1);

    // 2: lone repeat requester, two 2-word packets
    hlen[3] = 2;
    load[3] = 4;
    e0 = n_en;
    w0 = n_w;
    wait_done("t2_done");
    check("t2_en", 64'(n_en - e0), 64'd3);
    check("t2_nw", 64'(n_w - w0), 64'd4);
    check("t2_w1", 64'(wd[w0+1]), 64'(enc(3, 1, 1)));
    check("t2_w2", 64'(wd[w0+2]), 64'(enc(3, 2, 0)));
    check("t2_w3", 64'(wd[w0+3]), 64'(enc(3, 3, 1)));
    check("t2_pop", 64'(popcnt[3]), 64'd4);

    // 3: backpressure on a 4-word packet
    pat = '{1, 0, 0, 1, 0, 0, 1, 0, 1};
    out_ready = 1'b0;
    hlen[5] = 4;
    load[5] = 4;
    w0 = n_w;
    acc = 0;
    wait_valid("t3_valid");
    for (int c = 0; c < 9; c++) begin
      out_ready = pat[c][0];
      #1;
      check($sformatf("t3_v%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("t3_d%0d", c), 64'(out_data[15:0]), 64'(acc));
      check($sformatf("t3_p%0d", c), 64'(board_pop),
            pat[c] != 0 ? 64'h20 : 64'h0);
      check($sformatf("t3_l%0d", c), 64'(out_last), 64'(acc == 3));
      @(posedge clk);
      #1;
      if (pat[c] != 0)
        acc++;
    end
    out_ready = 1'b1;
    wait_done("t3_done");
    check("t3_pop", 64'(popcnt[5]), 64'd4);
    check("t3_nw", 64'(n_w - w0), 64'd4);
    check("t3_w3", 64'(wd[w0+3]), 64'(enc(5, 3, 1)));

    // 4: request withdrawn between REQ and WAIT
    hlen[1] = 1;
    load[1] = 2;
    w0 = n_w;
    wait_en("t4_req");
    @(posedge clk);
    #1;
    hold[1] = 1'b1;
    @(negedge clk);
    check("t4_wait_valid", 64'(out_valid), 64'd0);
    check("t4_wait_pop", 64'(board_pop), 64'd0);
    @(negedge clk);
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_nopop", 64'(popcnt[1]), 64'd0);
    check("t4_nw", 64'(n_w - w0), 64'd0);
    hold[1] = 1'b0;
    wait_done("t4_done");
    check("t4_pop", 64'(popcnt[1]), 64'd2);

    // 5: reset after word 2 of 5
    hlen[6] = 5;
    load[6] = 5;
    w0 = n_w;
    wait_valid("t5_valid");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset("t5_rst");
    hold[6] = 1'b1;
    hlen[6] = 3;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_popped", 64'(popcnt[6]), 64'd2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t5_idle%0d", c), 64'(busy), 64'd0);
    end
    hold[6] = 1'b0;
    wait_done("t5_done");
    check("t5_nw", 64'(n_w - w0), 64'd5);
    check("t5_w1", 64'(wd[w0+1]), 64'(enc(6, 1, 0)));
    check("t5_w2", 64'(wd[w0+2]), 64'(enc(6, 2, 0)));
    check("t5_w4", 64'(wd[w0+4]), 64'(enc(6, 4, 1)));

    // 6: zero length sends one word
    hlen[4] = 0;
    load[4] = 1;
    w0 = n_w;
    wait_done("t6_done");
    check("t6_nw", 64'(n_w - w0), 64'd1);
    check("t6_w0", 64'(wd[w0]), 64'(enc(4, 0, 1)));
    check("t6_pop", 64'(popcnt[4]), 64'd1);

    check("invariants", 64'(viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
